hams_bank_arb: RTL and testbench
================================

# hams_bank_arb

Two-requester arbiter that shares the NUM_MEM work BRAM banks between the sort controller (`hams_ctrl`), which drives all banks in lockstep, and a host load/readback port, which accesses one bank per cycle. It sits between both requesters and the `hams_syncbram` instances. It grants whole bursts, multiplexes address, data and write enables, and routes read data back to the requester that issued each read.

## Interface
Parameters:
- NUM_MEM, default NUM_ELEMENTS: number of banks.
- ADDR_WIDTH, default 10: bank address width.
- DATA_WIDTH, default 32: word width.
- RD_LAT, default 2: BRAM read latency in cycles (2 matches OUT_PIPELINE_ENA=1); legal range 1..4.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ctrl_req  in  1  controller requests the banks; held for the whole burst.
- ctrl_gnt  out  1  controller owns the banks.
- ctrl_rd  in  1  controller read strobe, all banks.
- ctrl_wr  in  NUM_MEM  per-bank controller write enables.
- ctrl_addr  in  NUM_MEM×ADDR_WIDTH  per-bank addresses.
- ctrl_wdata  in  NUM_MEM×DATA_WIDTH  per-bank write data.
- ctrl_rdata  out  NUM_MEM×DATA_WIDTH  returned read data.
- ctrl_rvalid  out  1  ctrl_rdata valid.
- host_req  in  1  host requests the banks.
- host_gnt  out  1  host owns the banks.
- host_rd, host_wr  in  1  host read / write strobes.
- host_bank  in  $clog2(NUM_MEM)  target bank.
- host_addr  in  ADDR_WIDTH  address.
- host_wdata  in  DATA_WIDTH  write data.
- host_rdata  out  DATA_WIDTH  returned read data.
- host_rvalid  out  1  host_rdata valid.
- mem_wr  out  NUM_MEM  bank write enables.
- mem_addr  out  NUM_MEM×ADDR_WIDTH  bank addresses.
- mem_wdata  out  NUM_MEM×DATA_WIDTH  bank write data.
- mem_rdata  in  NUM_MEM×DATA_WIDTH  bank read data.
- stat_ctrl_cycles, stat_host_cycles, stat_wait_cycles  out  32  statistics counters (see Configuration).

## Operation
- State machine states:
  - IDLE: no owner.
  - OWN_CTRL: controller owns the banks.
  - OWN_HOST: host owns the banks.
- Grants are registered and decoded from the state: ctrl_gnt = (state==OWN_CTRL), host_gnt = (state==OWN_HOST).
- From IDLE:
  - Only one requester active: that requester becomes owner.
  - Both active: the requester that was not last_owner becomes owner. last_owner resets to HOST, so the controller wins the first tie.
- From OWN_x:
  - While x_req stays high, stay in OWN_x. There is no preemption.
  - x_req low with the other requester's req high: hand off directly to the other requester.
  - x_req low with no other request: go to IDLE.
- last_owner updates whenever OWN_x is entered.
- Access qualification: an access takes effect only when req and gnt are both high. Unqualified strobes are ignored: no bank effect, no rvalid.
- Memory mux (combinational from the state):
  - OWN_CTRL: mem_* = ctrl_*, qualified.
  - OWN_HOST: only bank host_bank is driven. mem_wr[host_bank]=host_wr; all other mem_wr are 0. host_addr and host_wdata are broadcast to every bank.
  - IDLE: mem_wr all 0, mem_addr and mem_wdata 0.
- rd and wr high in the same cycle: the write wins and no read tag is issued.
- Read return:
  - Each qualified read pushes a tag {valid, owner, bank} into an RD_LAT-deep shift register.
  - At the output, tag.owner selects ctrl_rvalid or host_rvalid.
  - host_rdata = mem_rdata[tag.bank]. ctrl_rdata = mem_rdata (unregistered pass-through).
  - Reads already in flight across a handoff still return to their issuer.

## Timing
- Reset values: state=IDLE, last_owner=HOST, ctrl_gnt=host_gnt=0, tag pipe cleared, rvalid=0, stats=0. mem_wr=0 while in reset.
- Request to grant: req rising at edge t gives gnt high after edge t+1. The first access is possible in cycle t+1.
- Release to handoff: owner req low in cycle t gives the other gnt high after edge t+1, with zero bubble cycles.
- Read latency: a qualified read in cycle t gives rvalid in cycle t+RD_LAT.
- Back-to-back reads sustain 1 read per cycle.
- Reset mid-burst: grants drop and in-flight tags are discarded immediately (asynchronous reset). No rvalid appears afterwards for pre-reset reads.

## Configuration
- HAMS_BANK_ARB_STATS_EN defined:
  - stat_ctrl_cycles counts cycles with a qualified controller access.
  - stat_host_cycles counts cycles with a qualified host access.
  - stat_wait_cycles counts cycles where a requester has req=1 and gnt=0.
  - All counters saturate at 32'hFFFF_FFFF.
- Macro undefined: the stat_* ports still exist and are tied to 0, and no counter flops are built.

## Structure
- hams_pkg gains:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_OWN_CTRL, ARB_OWN_HOST} arb_state_e.
  - typedef enum logic {ARB_CTRL, ARB_HOST} arb_owner_e.
  - constant HAMS_BRAM_RD_LAT = 2.
- Sub-module hams_rd_tag_pipe: a parameterised shift register carrying {valid, owner, bank} with asynchronous clear.

## Test plan
- Tie on simultaneous requests: both req high from reset release → ctrl_gnt=1 one cycle later, host_gnt=0, stat_wait_cycles increments each waiting cycle.
- Handoff and fairness: ctrl drops req after 8 cycles with host_req held → host_gnt=1 on the next edge, no IDLE cycle. A repeat tie then goes to the controller (last_owner=HOST).
- Host write then read: write 32'hDEAD_BEEF to bank 2, addr 5; read it back → host_rvalid exactly 2 cycles after the read, host_rdata=32'hDEAD_BEEF, mem_wr[0,1,3] never asserted.
- Unqualified access: host_wr=1 while ctrl owns → bank contents unchanged, host_rvalid stays 0.
- In-flight read across handoff: ctrl reads in its last granted cycle → ctrl_rvalid 2 cycles later, even though host_gnt is already high.
- Reset mid-read: assert rst_n=0 one cycle after a host read → host_rvalid never asserts, grants=0, stats=0.

Source files
------------

// File: rtl/hams_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hams_pkg
// Description : Shared types and constants for the HAMS sorter bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package hams_pkg;

  localparam int NUM_ELEMENTS     = 4;
  localparam int HAMS_BRAM_RD_LAT = 2;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_OWN_CTRL = 2'd1,
    ARB_OWN_HOST = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_CTRL = 1'b0,
    ARB_HOST = 1'b1
  } arb_owner_e;

  // Bank-select width that stays legal for a single-bank build.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hams_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hams_rd_tag_pipe
// Description : Read-return tag delay line {valid, owner, bank}, async clear.
// Revision    : 1.0 - initial release
// ============================================================================
module hams_rd_tag_pipe
  import hams_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_owner,
  input  logic [BANK_W-1:0] in_bank,
  output logic              out_valid,
  output logic              out_owner,
  output logic [BANK_W-1:0] out_bank
);

  logic              r_valid [DEPTH];
  logic              r_owner [DEPTH];
  logic [BANK_W-1:0] r_bank  [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_owner[i] <= 1'(ARB_CTRL);
        r_bank[i]  <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_owner[0] <= in_owner;
      r_bank[0]  <= in_bank;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_owner[i] <= r_owner[i-1];
        r_bank[i]  <= r_bank[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_owner = r_owner[DEPTH-1];
  assign out_bank  = r_bank[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/hams_bank_arb.sv
`default_nettype none
// ============================================================================
// Module      : hams_bank_arb
// Description : Burst arbiter sharing the BRAM banks between the sort
//               controller and the host port. Optional statistics counters
//               are built when HAMS_BANK_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hams_bank_arb
  import hams_pkg::*;
#(
  parameter int NUM_MEM    = NUM_ELEMENTS,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = HAMS_BRAM_RD_LAT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ctrl_req,
  output logic                             ctrl_gnt,
  input  logic                             ctrl_rd,
  input  logic [NUM_MEM-1:0]               ctrl_wr,
  input  logic [NUM_MEM*ADDR_WIDTH-1:0]    ctrl_addr,
  input  logic [NUM_MEM*DATA_WIDTH-1:0]    ctrl_wdata,
  output logic [NUM_MEM*DATA_WIDTH-1:0]    ctrl_rdata,
  output logic                             ctrl_rvalid,
  input  logic                             host_req,
  output logic                             host_gnt,
  input  logic                             host_rd,
  input  logic                             host_wr,
  input  logic [bank_w(NUM_MEM)-1:0]       host_bank,
  input  logic [ADDR_WIDTH-1:0]            host_addr,
  input  logic [DATA_WIDTH-1:0]            host_wdata,
  output logic [DATA_WIDTH-1:0]            host_rdata,
  output logic                             host_rvalid,
  output logic [NUM_MEM-1:0]               mem_wr,
  output logic [NUM_MEM*ADDR_WIDTH-1:0]    mem_addr,
  output logic [NUM_MEM*DATA_WIDTH-1:0]    mem_wdata,
  input  logic [NUM_MEM*DATA_WIDTH-1:0]    mem_rdata,
  output logic [31:0]                      stat_ctrl_cycles,
  output logic [31:0]                      stat_host_cycles,
  output logic [31:0]                      stat_wait_cycles
);

  localparam int BANK_W = bank_w(NUM_MEM);

  localparam logic [1:0] S_IDLE     = ARB_IDLE;
  localparam logic [1:0] S_OWN_CTRL = ARB_OWN_CTRL;
  localparam logic [1:0] S_OWN_HOST = ARB_OWN_HOST;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  arb_owner_e  r_last_owner;

  logic        w_ctrl_q;
  logic        w_host_q;
  logic        w_ctrl_rd_issue;
  logic        w_host_rd_issue;
  logic        w_tag_valid;
  logic        w_tag_owner;
  logic [BANK_W-1:0] w_tag_bank;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OWN_CTRL: begin
        if (!ctrl_req) w_state_nxt = host_req ? S_OWN_HOST : S_IDLE;
      end
      S_OWN_HOST: begin
        if (!host_req) w_state_nxt = ctrl_req ? S_OWN_CTRL : S_IDLE;
      end
      default: begin
        // Tie goes to whoever did not own the banks most recently.
        if (ctrl_req && host_req)
          w_state_nxt = (r_last_owner == ARB_HOST) ? S_OWN_CTRL : S_OWN_HOST;
        else if (ctrl_req)
          w_state_nxt = S_OWN_CTRL;
        else if (host_req)
          w_state_nxt = S_OWN_HOST;
        else
          w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_owner <= ARB_HOST;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == S_OWN_CTRL && r_state != S_OWN_CTRL)
        r_last_owner <= ARB_CTRL;
      else if (w_state_nxt == S_OWN_HOST && r_state != S_OWN_HOST)
        r_last_owner <= ARB_HOST;
    end
  end

  assign ctrl_gnt = (r_state == S_OWN_CTRL);
  assign host_gnt = (r_state == S_OWN_HOST);
  assign w_ctrl_q = ctrl_req & ctrl_gnt;
  assign w_host_q = host_req & host_gnt;

  always_comb begin
    mem_wr    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_OWN_CTRL: begin
        mem_wr    = w_ctrl_q ? ctrl_wr : '0;
        mem_addr  = ctrl_addr;
        mem_wdata = ctrl_wdata;
      end
      S_OWN_HOST: begin
        mem_addr  = {NUM_MEM{host_addr}};
        mem_wdata = {NUM_MEM{host_wdata}};
        if (w_host_q && host_wr) mem_wr[host_bank] = 1'b1;
      end
      default: ;
    endcase
  end

  // A write in the same cycle as a read suppresses the read tag.
  assign w_ctrl_rd_issue = w_ctrl_q & ctrl_rd & ~(|ctrl_wr);
  assign w_host_rd_issue = w_host_q & host_rd & ~host_wr;

  hams_rd_tag_pipe #(
    .DEPTH  (RD_LAT),
    .BANK_W (BANK_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_ctrl_rd_issue | w_host_rd_issue),
    .in_owner  (w_host_rd_issue ? 1'(ARB_HOST) : 1'(ARB_CTRL)),
    .in_bank   (host_bank),
    .out_valid (w_tag_valid),
    .out_owner (w_tag_owner),
    .out_bank  (w_tag_bank)
  );

  assign ctrl_rvalid = w_tag_valid & (w_tag_owner == 1'(ARB_CTRL));
  assign host_rvalid = w_tag_valid & (w_tag_owner == 1'(ARB_HOST));
  assign ctrl_rdata  = mem_rdata;
  assign host_rdata  = mem_rdata[int'(w_tag_bank)*DATA_WIDTH +: DATA_WIDTH];

`ifdef HAMS_BANK_ARB_STATS_EN
  logic [31:0] r_stat_ctrl;
  logic [31:0] r_stat_host;
  logic [31:0] r_stat_wait;
  logic        w_ctrl_acc;
  logic        w_host_acc;
  logic        w_wait;

  assign w_ctrl_acc = w_ctrl_q & (ctrl_rd | (|ctrl_wr));
  assign w_host_acc = w_host_q & (host_rd | host_wr);
  assign w_wait     = (ctrl_req & ~ctrl_gnt) | (host_req & ~host_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ctrl <= '0;
      r_stat_host <= '0;
      r_stat_wait <= '0;
    end else begin
      if (w_ctrl_acc && r_stat_ctrl != 32'hFFFF_FFFF) r_stat_ctrl <= r_stat_ctrl + 32'd1;
      if (w_host_acc && r_stat_host != 32'hFFFF_FFFF) r_stat_host <= r_stat_host + 32'd1;
      if (w_wait     && r_stat_wait != 32'hFFFF_FFFF) r_stat_wait <= r_stat_wait + 32'd1;
    end
  end

  assign stat_ctrl_cycles = r_stat_ctrl;
  assign stat_host_cycles = r_stat_host;
  assign stat_wait_cycles = r_stat_wait;
`else
  assign stat_ctrl_cycles = '0;
  assign stat_host_cycles = '0;
  assign stat_wait_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hams_bank_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hams_bank_arb
// Description : Randomised scoreboard bench for hams_bank_arb with BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hams_bank_arb;

  localparam int NM  = 4;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 2;
`ifdef HAMS_BANK_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [NM*DW-1:0] wide_t;
  typedef struct {
    int    due;
    bit    is_host;
    wide_t data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ctrl_req = 1'b0, ctrl_gnt, ctrl_rd = 1'b0, ctrl_rvalid;
  logic [NM-1:0]     ctrl_wr = '0;
  logic [NM*AW-1:0]  ctrl_addr = '0;
  logic [NM*DW-1:0]  ctrl_wdata = '0, ctrl_rdata;
  logic              host_req = 1'b0, host_gnt, host_rd = 1'b0, host_wr = 1'b0, host_rvalid;
  logic [1:0]        host_bank = '0;
  logic [AW-1:0]     host_addr = '0;
  logic [DW-1:0]     host_wdata = '0, host_rdata;
  logic [NM-1:0]     mem_wr;
  logic [NM*AW-1:0]  mem_addr;
  logic [NM*DW-1:0]  mem_wdata, mem_rdata;
  logic [31:0]       stat_ctrl_cycles, stat_host_cycles, stat_wait_cycles;

  hams_bank_arb #(.NUM_MEM(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_req(ctrl_req), .ctrl_gnt(ctrl_gnt), .ctrl_rd(ctrl_rd), .ctrl_wr(ctrl_wr),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
    .ctrl_rvalid(ctrl_rvalid),
    .host_req(host_req), .host_gnt(host_gnt), .host_rd(host_rd), .host_wr(host_wr),
    .host_bank(host_bank), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_ctrl_cycles(stat_ctrl_cycles), .stat_host_cycles(stat_host_cycles),
    .stat_wait_cycles(stat_wait_cycles)
  );

  always #5 clk = ~clk;

  // Two-cycle-latency BRAM banks, 16 words each, cleared while in reset.
  logic [DW-1:0] bram [NM][16];
  wide_t p1, p2;
  always @(posedge clk) begin
    for (int b = 0; b < NM; b++) begin
      for (int a = 0; a < 16; a++)
        if (!rst_n) bram[b][a] <= '0;
      if (rst_n && mem_wr[b]) bram[b][mem_addr[b*AW +: 4]] <= mem_wdata[b*DW +: DW];
      p1[b*DW +: DW] <= bram[b][mem_addr[b*AW +: 4]];
    end
    p2 <= p1;
  end
  assign mem_rdata = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  function automatic void chk(string name, wide_t act, wide_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Reference model state: owner 0=none 1=ctrl 2=host.
  int          m_owner = 0;
  int          m_last  = 2;
  int unsigned m_sc = 0, m_sh = 0, m_sw = 0;
  logic [DW-1:0] shadow [NM][16];

  function automatic int next_owner(int cur, int last, bit creq, bit hreq);
    bit want [3];
    want[0] = 1'b0;
    want[1] = creq;
    want[2] = hreq;
    if (cur != 0 && want[cur]) return cur;
    if (cur != 0) return want[3-cur] ? 3 - cur : 0;
    if (creq && hreq) return 3 - last;
    return creq ? 1 : (hreq ? 2 : 0);
  endfunction

  // Monitor: every rvalid must match the head of the scoreboard on its due cycle.
  always @(negedge clk) begin
    if (ctrl_rvalid || host_rvalid) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL rvalid_unexpected @cyc %0d: got ctrl=%0b host=%0b expected none",
                 cyc, ctrl_rvalid, host_rvalid);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid_owner", wide_t'({ctrl_rvalid, host_rvalid}),
            mon_e.is_host ? wide_t'(2'b01) : wide_t'(2'b10));
        if (mon_e.is_host) chk("host_rdata", wide_t'(host_rdata), mon_e.data);
        else               chk("ctrl_rdata", ctrl_rdata, mon_e.data);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL rvalid_missing @cyc %0d: got no rvalid expected one due cyc %0d",
               cyc, mon_e.due);
    end
  end

  // Stimulus for the coming cycle.
  logic              s_creq, s_crd, s_hreq, s_hrd, s_hwr;
  logic [NM-1:0]     s_cwr;
  logic [NM*AW-1:0]  s_caddr;
  logic [NM*DW-1:0]  s_cwdata;
  logic [1:0]        s_hbank;
  logic [AW-1:0]     s_haddr;
  logic [DW-1:0]     s_hwdata;

  task automatic clear_strobes();
    s_crd = 0; s_cwr = '0; s_caddr = '0; s_cwdata = '0;
    s_hrd = 0; s_hwr = 0; s_hbank = '0; s_haddr = '0; s_hwdata = '0;
  endtask

  task automatic drive();
    ctrl_req = s_creq; ctrl_rd = s_crd; ctrl_wr = s_cwr; ctrl_addr = s_caddr;
    ctrl_wdata = s_cwdata; host_req = s_hreq; host_rd = s_hrd; host_wr = s_hwr;
    host_bank = s_hbank; host_addr = s_haddr; host_wdata = s_hwdata;
  endtask

  task automatic chk_stats();
    chk("stat_ctrl", wide_t'(stat_ctrl_cycles), STATS ? wide_t'(m_sc) : '0);
    chk("stat_host", wide_t'(stat_host_cycles), STATS ? wide_t'(m_sh) : '0);
    chk("stat_wait", wide_t'(stat_wait_cycles), STATS ? wide_t'(m_sw) : '0);
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step();
    logic [NM-1:0] ewr;
    wide_t         rd;
    exp_t          e;
    int            nxt;
    chk("ctrl_gnt", wide_t'(ctrl_gnt), wide_t'(m_owner == 1));
    chk("host_gnt", wide_t'(host_gnt), wide_t'(m_owner == 2));
    chk_stats();
    drive();
    #1;
    ewr = '0;
    if (m_owner == 1 && s_creq) ewr = s_cwr;
    if (m_owner == 2 && s_hreq && s_hwr) ewr[s_hbank] = 1'b1;
    chk("mem_wr", wide_t'(mem_wr), wide_t'(ewr));
    if (m_owner == 1 && s_creq && s_crd && s_cwr == '0) begin
      for (int b = 0; b < NM; b++) rd[b*DW +: DW] = shadow[b][s_caddr[b*AW +: 4]];
      e.due = cyc + LAT; e.is_host = 1'b0; e.data = rd;
      sb.push_back(e);
    end
    if (m_owner == 2 && s_hreq && s_hrd && !s_hwr) begin
      e.due = cyc + LAT; e.is_host = 1'b1; e.data = wide_t'(shadow[s_hbank][s_haddr[3:0]]);
      sb.push_back(e);
    end
    for (int b = 0; b < NM; b++)
      if (ewr[b])
        shadow[b][(m_owner == 1) ? s_caddr[b*AW +: 4] : s_haddr[3:0]] =
          (m_owner == 1) ? s_cwdata[b*DW +: DW] : s_hwdata;
    if (m_owner == 1 && s_creq && (s_crd || s_cwr != '0)) m_sc++;
    if (m_owner == 2 && s_hreq && (s_hrd || s_hwr)) m_sh++;
    if ((s_creq && m_owner != 1) || (s_hreq && m_owner != 2)) m_sw++;
    nxt = next_owner(m_owner, m_last, s_creq, s_hreq);
    if (nxt != 0) m_last = nxt;
    m_owner = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    sb.delete();
    s_creq = 0; s_hreq = 0;
    clear_strobes();
    drive();
    #1;
    chk("rst_ctrl_gnt", wide_t'(ctrl_gnt), '0);
    chk("rst_host_gnt", wide_t'(host_gnt), '0);
    chk("rst_mem_wr", wide_t'(mem_wr), '0);
    chk("rst_rvalid", wide_t'({ctrl_rvalid, host_rvalid}), '0);
    m_owner = 0; m_last = 2; m_sc = 0; m_sh = 0; m_sw = 0;
    chk_stats();
    for (int b = 0; b < NM; b++)
      for (int a = 0; a < 16; a++) shadow[b][a] = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int c_left = 0;
  int h_left = 0;

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);

    // Simultaneous requests from reset: controller wins the first tie.
    s_creq = 1; s_hreq = 1; clear_strobes();
    repeat (9) step();
    // Controller reads in its last cycle, then releases straight to the host.
    s_crd = 1; s_caddr = {10'd3, 10'd2, 10'd1, 10'd0};
    step();
    s_creq = 0; clear_strobes();
    // Host write then readback on bank 2, address 5.
    s_hwr = 1; s_hbank = 2'd2; s_haddr = 10'd5; s_hwdata = 32'hDEAD_BEEF;
    step();
    clear_strobes(); s_hrd = 1; s_hbank = 2'd2; s_haddr = 10'd5;
    step();
    clear_strobes();
    repeat (3) step();
    s_hreq = 0;
    repeat (2) step();
    // Repeat tie goes to the controller; host strobes meanwhile are unqualified.
    s_creq = 1; s_hreq = 1;
    s_hwr = 1; s_hbank = 2'd2; s_haddr = 10'd5; s_hwdata = 32'h0;
    repeat (4) step();
    clear_strobes(); s_creq = 0;
    s_hrd = 1; s_hbank = 2'd2; s_haddr = 10'd5;
    repeat (2) step();

    // Randomised bursts and strobes.
    for (int k = 0; k < 600; k++) begin
      if (c_left == 0 && $urandom_range(3) == 0) c_left = $urandom_range(10, 1);
      if (h_left == 0 && $urandom_range(3) == 0) h_left = $urandom_range(10, 1);
      s_creq = (c_left > 0);
      s_hreq = (h_left > 0);
      if (c_left > 0) c_left--;
      if (h_left > 0) h_left--;
      s_crd = ($urandom_range(2) == 0);
      s_cwr = ($urandom_range(3) == 0) ? NM'($urandom) : '0;
      for (int b = 0; b < NM; b++) begin
        s_caddr[b*AW +: AW]  = AW'($urandom_range(15));
        s_cwdata[b*DW +: DW] = $urandom;
      end
      s_hrd = ($urandom_range(2) == 0);
      s_hwr = ($urandom_range(2) == 0);
      s_hbank = 2'($urandom_range(NM - 1));
      s_haddr = AW'($urandom_range(15));
      s_hwdata = $urandom;
      step();
    end

    // Reset one cycle after a host read: the read must never return.
    s_creq = 0; s_hreq = 1; clear_strobes();
    repeat (3) step();
    s_hrd = 1; s_hbank = 2'd1; s_haddr = 10'd7;
    step();
    do_reset(4);

    s_creq = 0; s_hreq = 0; clear_strobes();
    repeat (5) step();
    chk("scoreboard_drained", wide_t'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
